maxi_read_arbiter: RTL and testbench

- Shares one AXI3 master read port (64-bit data, 4-bit burst length) among `NREQ` internal read requesters, such as the DMA readers inside `IP_Top`.
- Grants requesters round-robin and issues one burst at a time on the master AR channel.
- Steers the returning R beats to the granted requester until `RLAST`.
- Sits between the reader engines and the `MAXI0`/`MAXI1` read pins.

---
 rtl/maxi_arb_pkg.sv | 15 +
 rtl/rr_arbiter.sv | 31 +++
 rtl/maxi_read_arbiter.sv | 147 ++++++++++++++
 tb/tb_maxi_read_arbiter.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/maxi_arb_pkg.sv
// Shared types and AXI constants for the MAXI read arbiter and its
// round-robin pick logic.
package maxi_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    localparam logic [1:0] ARSIZE_8B    = 2'b11;
    localparam logic [1:0] ARBURST_INCR = 2'b01;
    localparam logic [1:0] RRESP_OKAY   = 2'b00;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request scanning upward from ptr,
// wrapping modulo NREQ. Shared with the write-side arbiter.
module rr_arbiter #(
    parameter int NREQ  = 2,
    parameter int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [NREQ-1:0]  gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        gnt       = '0;
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        cand      = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = IDX_W'((int'(ptr) + i) % NREQ);
            if (!gnt_valid && req[cand]) begin
                gnt_valid = 1'b1;
                gnt_idx   = cand;
                gnt[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/maxi_read_arbiter.sv
// Shares one AXI3 read master among NREQ requesters, one burst at a time.
// Define MAXI_ARB_LENCHECK_EN to build the beat counter that drives len_err.
module maxi_read_arbiter
    import maxi_arb_pkg::*;
#(
    parameter int NREQ   = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
) (
    input  logic                         IP_CLK,
    input  logic                         IP_ARESET_N,
    input  logic [NREQ-1:0][ADDR_W-1:0]  req_araddr,
    input  logic [NREQ-1:0][3:0]         req_arlen,
    input  logic [NREQ-1:0]              req_arvalid,
    output logic [NREQ-1:0]              req_arready,
    output logic [DATA_W-1:0]            req_rdata,
    output logic                         req_rlast,
    output logic [NREQ-1:0]              req_rvalid,
    input  logic [NREQ-1:0]              req_rready,
    output logic [ADDR_W-1:0]            MAXI_ARADDR,
    output logic                         MAXI_ARVALID,
    input  logic                         MAXI_ARREADY,
    output logic [3:0]                   MAXI_ARLEN,
    output logic [1:0]                   MAXI_ARSIZE,
    output logic [1:0]                   MAXI_ARBURST,
    input  logic [DATA_W-1:0]            MAXI_RDATA,
    input  logic                         MAXI_RVALID,
    output logic                         MAXI_RREADY,
    input  logic [1:0]                   MAXI_RRESP,
    input  logic                         MAXI_RLAST,
    output logic                         rresp_err,
    output logic                         len_err
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t             state;
    logic [IDX_W-1:0]   grant;
    logic [IDX_W-1:0]   rr_ptr;
    logic [ADDR_W-1:0]  araddr_q;
    logic [3:0]         arlen_q;
    logic               arvalid_q;
    logic               rresp_err_q;

    logic [NREQ-1:0]    pick_onehot;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_valid;
    logic               in_data;
    logic               beat;

    rr_arbiter #(.NREQ(NREQ), .IDX_W(IDX_W)) u_rr_arbiter (
        .req       (req_arvalid),
        .ptr       (rr_ptr),
        .gnt       (pick_onehot),
        .gnt_idx   (pick_idx),
        .gnt_valid (pick_valid)
    );

    assign in_data = (state == DATA);
    assign beat    = in_data & MAXI_RVALID & MAXI_RREADY;

    // Acceptance is suppressed while reset is held so no request is lost.
    assign req_arready  = (state == IDLE && IP_ARESET_N) ? pick_onehot : '0;
    assign MAXI_ARADDR  = araddr_q;
    assign MAXI_ARLEN   = arlen_q;
    assign MAXI_ARVALID = arvalid_q;
    assign MAXI_ARSIZE  = ARSIZE_8B;
    assign MAXI_ARBURST = ARBURST_INCR;
    assign MAXI_RREADY  = in_data & req_rready[grant];
    assign req_rdata    = in_data ? MAXI_RDATA : '0;
    assign req_rlast    = in_data & MAXI_RLAST;
    assign rresp_err    = rresp_err_q;

    always_comb begin
        req_rvalid = '0;
        if (in_data) begin
            req_rvalid[grant] = MAXI_RVALID;
        end
    end

    always_ff @(posedge IP_CLK or negedge IP_ARESET_N) begin
        if (!IP_ARESET_N) begin
            state       <= IDLE;
            grant       <= '0;
            rr_ptr      <= '0;
            araddr_q    <= '0;
            arlen_q     <= '0;
            arvalid_q   <= 1'b0;
            rresp_err_q <= 1'b0;
        end else begin
            if (beat && MAXI_RRESP != RRESP_OKAY) begin
                rresp_err_q <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        grant     <= pick_idx;
                        araddr_q  <= req_araddr[pick_idx];
                        arlen_q   <= req_arlen[pick_idx];
                        arvalid_q <= 1'b1;
                        state     <= ADDR;
                    end
                end
                ADDR: begin
                    if (MAXI_ARREADY) begin
                        arvalid_q <= 1'b0;
                        state     <= DATA;
                    end
                end
                DATA: begin
                    if (beat && MAXI_RLAST) begin
                        rr_ptr <= (grant == IDX_W'(NREQ - 1)) ? '0 : grant + 1'b1;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MAXI_ARB_LENCHECK_EN
    logic [3:0] beat_cnt;
    logic       len_err_q;

    // A length error is RLAST disagreeing with "this is beat arlen_q".
    always_ff @(posedge IP_CLK or negedge IP_ARESET_N) begin
        if (!IP_ARESET_N) begin
            beat_cnt  <= '0;
            len_err_q <= 1'b0;
        end else begin
            if (state == ADDR && MAXI_ARREADY) begin
                beat_cnt <= '0;
            end else if (beat) begin
                beat_cnt <= beat_cnt + 4'd1;
            end
            if (beat && (MAXI_RLAST != (beat_cnt == arlen_q))) begin
                len_err_q <= 1'b1;
            end
        end
    end

    assign len_err = len_err_q;
`else
    assign len_err = 1'b0;
`endif

endmodule

// File: tb/tb_maxi_read_arbiter.sv
// Directed testbench for maxi_read_arbiter with NREQ=2; inputs change at the
// falling edge and outputs are sampled 1 time unit later.
module tb_maxi_read_arbiter;

    localparam int NREQ   = 2;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 64;

`ifdef MAXI_ARB_LENCHECK_EN
    localparam logic EXP_LEN_ERR = 1'b1;
`else
    localparam logic EXP_LEN_ERR = 1'b0;
`endif

    logic                        IP_CLK = 1'b0;
    logic                        IP_ARESET_N;
    logic [NREQ-1:0][ADDR_W-1:0] req_araddr;
    logic [NREQ-1:0][3:0]        req_arlen;
    logic [NREQ-1:0]             req_arvalid;
    logic [NREQ-1:0]             req_arready;
    logic [DATA_W-1:0]           req_rdata;
    logic                        req_rlast;
    logic [NREQ-1:0]             req_rvalid;
    logic [NREQ-1:0]             req_rready;
    logic [ADDR_W-1:0]           MAXI_ARADDR;
    logic                        MAXI_ARVALID;
    logic                        MAXI_ARREADY;
    logic [3:0]                  MAXI_ARLEN;
    logic [1:0]                  MAXI_ARSIZE;
    logic [1:0]                  MAXI_ARBURST;
    logic [DATA_W-1:0]           MAXI_RDATA;
    logic                        MAXI_RVALID;
    logic                        MAXI_RREADY;
    logic [1:0]                  MAXI_RRESP;
    logic                        MAXI_RLAST;
    logic                        rresp_err;
    logic                        len_err;

    int checks   = 0;
    int failures = 0;

    always #5 IP_CLK = ~IP_CLK;

    maxi_read_arbiter #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .IP_CLK       (IP_CLK),
        .IP_ARESET_N  (IP_ARESET_N),
        .req_araddr   (req_araddr),
        .req_arlen    (req_arlen),
        .req_arvalid  (req_arvalid),
        .req_arready  (req_arready),
        .req_rdata    (req_rdata),
        .req_rlast    (req_rlast),
        .req_rvalid   (req_rvalid),
        .req_rready   (req_rready),
        .MAXI_ARADDR  (MAXI_ARADDR),
        .MAXI_ARVALID (MAXI_ARVALID),
        .MAXI_ARREADY (MAXI_ARREADY),
        .MAXI_ARLEN   (MAXI_ARLEN),
        .MAXI_ARSIZE  (MAXI_ARSIZE),
        .MAXI_ARBURST (MAXI_ARBURST),
        .MAXI_RDATA   (MAXI_RDATA),
        .MAXI_RVALID  (MAXI_RVALID),
        .MAXI_RREADY  (MAXI_RREADY),
        .MAXI_RRESP   (MAXI_RRESP),
        .MAXI_RLAST   (MAXI_RLAST),
        .rresp_err    (rresp_err),
        .len_err      (len_err)
    );

    task automatic clear_inputs;
        req_araddr   = '0;
        req_arlen    = '0;
        req_arvalid  = '0;
        req_rready   = '0;
        MAXI_ARREADY = 1'b0;
        MAXI_RDATA   = '0;
        MAXI_RVALID  = 1'b0;
        MAXI_RRESP   = 2'b00;
        MAXI_RLAST   = 1'b0;
    endtask

    task automatic do_reset;
        IP_ARESET_N = 1'b0;
        clear_inputs();
        repeat (2) @(negedge IP_CLK);
        IP_ARESET_N = 1'b1;
        @(negedge IP_CLK);
    endtask

    // Runs one complete burst with an always-ready slave and requester.
    task automatic drive_burst(input logic sel, input logic [31:0] addr,
                               input logic [3:0] len, input int last_beat,
                               input int err_beat);
        req_araddr[sel]  = addr;
        req_arlen[sel]   = len;
        req_arvalid      = '0;
        req_arvalid[sel] = 1'b1;
        req_rready       = '1;
        @(negedge IP_CLK);
        req_arvalid  = '0;
        MAXI_ARREADY = 1'b1;
        @(negedge IP_CLK);
        MAXI_ARREADY = 1'b0;
        for (int b = 0; b <= last_beat; b++) begin
            MAXI_RVALID = 1'b1;
            MAXI_RDATA  = 64'hD000 + 64'(b);
            MAXI_RLAST  = (b == last_beat);
            MAXI_RRESP  = (b == err_beat) ? 2'b10 : 2'b00;
            @(negedge IP_CLK);
        end
        MAXI_RVALID = 1'b0;
        MAXI_RLAST  = 1'b0;
        MAXI_RRESP  = 2'b00;
    endtask

    task automatic test_reset;
        IP_ARESET_N = 1'b0;
        clear_inputs();
        req_arvalid = 2'b11;
        req_rready  = 2'b11;
        MAXI_RVALID = 1'b1;
        MAXI_RLAST  = 1'b1;
        MAXI_RDATA  = 64'h1234;
        @(negedge IP_CLK);
        #1;
        checks++; if (req_arready !== 2'b00) begin failures++; $display("[TB] FAIL reset_arready got=%b exp=00", req_arready); end
        checks++; if (MAXI_ARVALID !== 1'b0) begin failures++; $display("[TB] FAIL reset_arvalid got=%b exp=0", MAXI_ARVALID); end
        checks++; if (MAXI_ARADDR !== 32'h0 || MAXI_ARLEN !== 4'h0) begin failures++; $display("[TB] FAIL reset_araddr_len got=%h/%h exp=0/0", MAXI_ARADDR, MAXI_ARLEN); end
        checks++; if (MAXI_ARSIZE !== 2'b11 || MAXI_ARBURST !== 2'b01) begin failures++; $display("[TB] FAIL reset_size_burst got=%b/%b exp=11/01", MAXI_ARSIZE, MAXI_ARBURST); end
        checks++; if (MAXI_RREADY !== 1'b0 || req_rvalid !== 2'b00) begin failures++; $display("[TB] FAIL reset_rpath got=%b/%b exp=0/00", MAXI_RREADY, req_rvalid); end
        checks++; if (req_rdata !== 64'h0 || req_rlast !== 1'b0) begin failures++; $display("[TB] FAIL reset_rdata got=%h/%b exp=0/0", req_rdata, req_rlast); end
        checks++; if (rresp_err !== 1'b0 || len_err !== 1'b0) begin failures++; $display("[TB] FAIL reset_errs got=%b/%b exp=0/0", rresp_err, len_err); end
        do_reset();
    endtask

    task automatic test_single;
        do_reset();
        req_araddr[0] = 32'h1000;
        req_arlen[0]  = 4'd3;
        req_arvalid   = 2'b01;
        req_rready    = 2'b11;
        #1;
        checks++; if (req_arready !== 2'b01) begin failures++; $display("[TB] FAIL single_arready got=%b exp=01", req_arready); end
        checks++; if (MAXI_ARVALID !== 1'b0) begin failures++; $display("[TB] FAIL single_arvalid_idle got=%b exp=0", MAXI_ARVALID); end
        @(negedge IP_CLK);
        req_arvalid = 2'b00;
        #1;
        checks++; if (MAXI_ARVALID !== 1'b1) begin failures++; $display("[TB] FAIL single_arvalid got=%b exp=1", MAXI_ARVALID); end
        checks++; if (MAXI_ARADDR !== 32'h1000 || MAXI_ARLEN !== 4'd3) begin failures++; $display("[TB] FAIL single_addr_len got=%h/%0d exp=1000/3", MAXI_ARADDR, MAXI_ARLEN); end
        MAXI_ARREADY = 1'b1;
        @(negedge IP_CLK);
        MAXI_ARREADY = 1'b0;
        for (int b = 0; b < 4; b++) begin
            MAXI_RVALID = 1'b1;
            MAXI_RDATA  = 64'hA000 + 64'(b);
            MAXI_RLAST  = (b == 3);
            #1;
            checks++; if (req_rvalid !== 2'b01 || MAXI_RREADY !== 1'b1) begin failures++; $display("[TB] FAIL single_rvalid beat=%0d got=%b/%b exp=01/1", b, req_rvalid, MAXI_RREADY); end
            checks++; if (req_rdata !== 64'hA000 + 64'(b) || req_rlast !== (b == 3)) begin failures++; $display("[TB] FAIL single_rdata beat=%0d got=%h/%b exp=%h/%b", b, req_rdata, req_rlast, 64'hA000 + 64'(b), (b == 3)); end
            checks++; if (MAXI_ARVALID !== 1'b0) begin failures++; $display("[TB] FAIL single_ar_quiet beat=%0d got=%b exp=0", b, MAXI_ARVALID); end
            @(negedge IP_CLK);
        end
        MAXI_RLAST = 1'b0;
        #1;
        checks++; if (MAXI_RREADY !== 1'b0 || req_rvalid !== 2'b00 || MAXI_ARVALID !== 1'b0) begin failures++; $display("[TB] FAIL single_back_idle got=%b/%b/%b exp=0/00/0", MAXI_RREADY, req_rvalid, MAXI_ARVALID); end
        MAXI_RVALID = 1'b0;
    endtask

    task automatic test_contention;
        logic [1:0] exp_oh;
        do_reset();
        req_araddr[0] = 32'h2000;
        req_araddr[1] = 32'h3000;
        req_arlen[0]  = 4'd0;
        req_arlen[1]  = 4'd0;
        req_arvalid   = 2'b11;
        req_rready    = 2'b11;
        for (int n = 0; n < 4; n++) begin
            exp_oh = (n % 2 == 0) ? 2'b01 : 2'b10;
            #1;
            checks++; if (req_arready !== exp_oh) begin failures++; $display("[TB] FAIL contention_grant n=%0d got=%b exp=%b", n, req_arready, exp_oh); end
            @(negedge IP_CLK);
            MAXI_ARREADY = 1'b1;
            #1;
            checks++; if (MAXI_ARVALID !== 1'b1 || MAXI_ARADDR !== ((n % 2 == 0) ? 32'h2000 : 32'h3000)) begin failures++; $display("[TB] FAIL contention_addr n=%0d got=%b/%h", n, MAXI_ARVALID, MAXI_ARADDR); end
            checks++; if (req_arready !== 2'b00) begin failures++; $display("[TB] FAIL contention_no_grant_busy n=%0d got=%b exp=00", n, req_arready); end
            @(negedge IP_CLK);
            MAXI_ARREADY = 1'b0;
            MAXI_RVALID  = 1'b1;
            MAXI_RLAST   = 1'b1;
            MAXI_RDATA   = 64'(n);
            #1;
            checks++; if (MAXI_ARVALID !== 1'b0 || req_rvalid !== exp_oh) begin failures++; $display("[TB] FAIL contention_data n=%0d got=%b/%b exp=0/%b", n, MAXI_ARVALID, req_rvalid, exp_oh); end
            @(negedge IP_CLK);
            MAXI_RVALID = 1'b0;
            MAXI_RLAST  = 1'b0;
        end
        req_arvalid = 2'b00;
    endtask

    task automatic test_back_to_back;
        do_reset();
        req_araddr[0] = 32'h5000;
        req_arlen[0]  = 4'd0;
        req_arvalid   = 2'b01;
        req_rready    = 2'b11;
        for (int n = 0; n < 3; n++) begin
            #1;
            checks++; if (req_arready !== 2'b01) begin failures++; $display("[TB] FAIL b2b_grant n=%0d got=%b exp=01", n, req_arready); end
            @(negedge IP_CLK);
            MAXI_ARREADY = 1'b1;
            @(negedge IP_CLK);
            MAXI_ARREADY = 1'b0;
            MAXI_RVALID  = 1'b1;
            MAXI_RLAST   = 1'b1;
            @(negedge IP_CLK);
            MAXI_RVALID = 1'b0;
            MAXI_RLAST  = 1'b0;
        end
        req_arvalid = 2'b00;
    endtask

    task automatic test_backpressure;
        int   k;
        int   ncyc;
        logic rdy;
        do_reset();
        req_araddr[0] = 32'h4000;
        req_arlen[0]  = 4'd3;
        req_arvalid   = 2'b01;
        @(negedge IP_CLK);
        req_arvalid   = 2'b00;
        req_araddr[0] = 32'hDEAD_0000;
        req_arlen[0]  = 4'hF;
        for (int c = 0; c < 6; c++) begin
            MAXI_ARREADY = (c == 5);
            #1;
            checks++; if (MAXI_ARVALID !== 1'b1 || MAXI_ARADDR !== 32'h4000 || MAXI_ARLEN !== 4'd3) begin failures++; $display("[TB] FAIL bp_addr_hold c=%0d got=%b/%h/%0d exp=1/4000/3", c, MAXI_ARVALID, MAXI_ARADDR, MAXI_ARLEN); end
            @(negedge IP_CLK);
        end
        MAXI_ARREADY = 1'b0;
        k    = 0;
        ncyc = 0;
        rdy  = 1'b1;
        for (int c = 0; c < 20 && k < 4; c++) begin
            req_rready  = {1'b0, rdy};
            MAXI_RVALID = 1'b1;
            MAXI_RDATA  = 64'hB000 + 64'(k);
            MAXI_RLAST  = (k == 3);
            #1;
            checks++; if (MAXI_RREADY !== rdy || req_rvalid !== 2'b01) begin failures++; $display("[TB] FAIL bp_rready c=%0d got=%b/%b exp=%b/01", c, MAXI_RREADY, req_rvalid, rdy); end
            checks++; if (req_rdata !== 64'hB000 + 64'(k)) begin failures++; $display("[TB] FAIL bp_rdata c=%0d got=%h exp=%h", c, req_rdata, 64'hB000 + 64'(k)); end
            if (rdy) k++;
            rdy = ~rdy;
            ncyc++;
            @(negedge IP_CLK);
        end
        checks++; if (k != 4 || ncyc != 7) begin failures++; $display("[TB] FAIL bp_beat_count got=%0d/%0d exp=4/7", k, ncyc); end
        req_rready = 2'b11;
        MAXI_RLAST = 1'b0;
        #1;
        checks++; if (MAXI_RREADY !== 1'b0 || req_rvalid !== 2'b00) begin failures++; $display("[TB] FAIL bp_back_idle got=%b/%b exp=0/00", MAXI_RREADY, req_rvalid); end
        MAXI_RVALID = 1'b0;
    endtask

    task automatic test_rresp_err;
        do_reset();
        #1;
        checks++; if (rresp_err !== 1'b0) begin failures++; $display("[TB] FAIL rresp_initial got=%b exp=0", rresp_err); end
        drive_burst(1'b0, 32'h6000, 4'd3, 3, -1);
        #1;
        checks++; if (rresp_err !== 1'b0) begin failures++; $display("[TB] FAIL rresp_okay_burst got=%b exp=0", rresp_err); end
        drive_burst(1'b0, 32'h6000, 4'd3, 3, 2);
        #1;
        checks++; if (rresp_err !== 1'b1) begin failures++; $display("[TB] FAIL rresp_set got=%b exp=1", rresp_err); end
        drive_burst(1'b1, 32'h6100, 4'd1, 1, -1);
        drive_burst(1'b0, 32'h6200, 4'd0, 0, -1);
        #1;
        checks++; if (rresp_err !== 1'b1) begin failures++; $display("[TB] FAIL rresp_sticky got=%b exp=1", rresp_err); end
        do_reset();
        #1;
        checks++; if (rresp_err !== 1'b0) begin failures++; $display("[TB] FAIL rresp_cleared got=%b exp=0", rresp_err); end
    endtask

    task automatic test_len_check;
        do_reset();
        drive_burst(1'b0, 32'h7000, 4'd3, 3, -1);
        #1;
        checks++; if (len_err !== 1'b0) begin failures++; $display("[TB] FAIL len_good_burst got=%b exp=0", len_err); end
        drive_burst(1'b0, 32'h7100, 4'd3, 2, -1);
        #1;
        checks++; if (len_err !== EXP_LEN_ERR) begin failures++; $display("[TB] FAIL len_short_burst got=%b exp=%b", len_err, EXP_LEN_ERR); end
        req_arvalid = 2'b11;
        #1;
        checks++; if (req_arready !== 2'b10 || MAXI_ARVALID !== 1'b0) begin failures++; $display("[TB] FAIL len_back_idle got=%b/%b exp=10/0", req_arready, MAXI_ARVALID); end
        req_arvalid = 2'b00;
    endtask

    task automatic test_reset_mid_burst;
        do_reset();
        req_araddr[0] = 32'h8000;
        req_arlen[0]  = 4'd3;
        req_arvalid   = 2'b01;
        req_rready    = 2'b11;
        @(negedge IP_CLK);
        req_arvalid  = 2'b00;
        MAXI_ARREADY = 1'b1;
        @(negedge IP_CLK);
        MAXI_ARREADY = 1'b0;
        for (int b = 0; b < 2; b++) begin
            MAXI_RVALID = 1'b1;
            MAXI_RDATA  = 64'hC000 + 64'(b);
            @(negedge IP_CLK);
        end
        MAXI_RDATA = 64'hC002;
        #1;
        checks++; if (MAXI_RREADY !== 1'b1 || req_rvalid !== 2'b01) begin failures++; $display("[TB] FAIL midrst_before got=%b/%b exp=1/01", MAXI_RREADY, req_rvalid); end
        IP_ARESET_N = 1'b0;
        #1;
        checks++; if (MAXI_RREADY !== 1'b0 || req_rvalid !== 2'b00 || MAXI_ARVALID !== 1'b0) begin failures++; $display("[TB] FAIL midrst_drop got=%b/%b/%b exp=0/00/0", MAXI_RREADY, req_rvalid, MAXI_ARVALID); end
        @(negedge IP_CLK);
        MAXI_RVALID   = 1'b0;
        IP_ARESET_N   = 1'b1;
        req_araddr[1] = 32'h9000;
        req_arlen[1]  = 4'd1;
        req_arvalid   = 2'b10;
        #1;
        checks++; if (req_arready !== 2'b10) begin failures++; $display("[TB] FAIL midrst_regrant got=%b exp=10", req_arready); end
        @(negedge IP_CLK);
        req_arvalid = 2'b00;
        #1;
        checks++; if (MAXI_ARVALID !== 1'b1 || MAXI_ARADDR !== 32'h9000) begin failures++; $display("[TB] FAIL midrst_addr got=%b/%h exp=1/9000", MAXI_ARVALID, MAXI_ARADDR); end
        do_reset();
    endtask

    initial begin
        IP_ARESET_N = 1'b0;
        clear_inputs();
        test_reset();
        test_single();
        test_contention();
        test_back_to_back();
        test_backpressure();
        test_rresp_err();
        test_len_check();
        test_reset_mid_burst();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
